// File: rtl/data_ram_resp.sv
// Data-memory responder for the MEM-stage load/store port: captures one word request,
// waits WAIT_CYCLES, performs a byte-lane read or write on an internal array, then acks.
module data_ram_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        busy
);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_we_q, req_we_d;
    logic [ADDR_W-1:0]   req_idx_q, req_idx_d;
    logic [3:0]          req_sel_q, req_sel_d;
    logic [31:0]         req_wdata_q, req_wdata_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                acc_en;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_idx;
    logic [3:0]          acc_sel;
    logic [31:0]         acc_wdata;
    logic [31:0]         lane_mask;

    logic [31:0]         mem_q [2**ADDR_W];

    logic                unused_addr;
    assign unused_addr = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_we_d    = req_we_q;
        req_idx_d   = req_idx_q;
        req_sel_d   = req_sel_q;
        req_wdata_d = req_wdata_q;
        ack_d       = 1'b0;
        busy_d      = busy_q;
        acc_en      = 1'b0;
        acc_we      = req_we_q;
        acc_idx     = req_idx_q;
        acc_sel     = req_sel_q;
        acc_wdata   = req_wdata_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (mem_ce) begin
                    req_we_d    = mem_we;
                    req_idx_d   = mem_addr[ADDR_W+1:2];
                    req_sel_d   = mem_sel;
                    req_wdata_d = mem_wdata;
                    busy_d      = 1'b1;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        // zero wait states: the access uses the live inputs at the capture edge
                        acc_en    = 1'b1;
                        acc_we    = mem_we;
                        acc_idx   = mem_addr[ADDR_W+1:2];
                        acc_sel   = mem_sel;
                        acc_wdata = mem_wdata;
                        ack_d     = 1'b1;
                        state_d   = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    acc_en  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{acc_sel[i]}};
        rdata_d = (acc_en && !acc_we) ? (mem_q[acc_idx] & lane_mask) : 32'h0;
    end

    // Array has no reset; writes are also blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst && acc_en && acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_we_q    <= 1'b0;
            req_idx_q   <= '0;
            req_sel_q   <= '0;
            req_wdata_q <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_we_q    <= req_we_d;
            req_idx_q   <= req_idx_d;
            req_sel_q   <= req_sel_d;
            req_wdata_q <= req_wdata_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ack   = ack_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Scoreboard bench for data_ram_resp: a WAIT_CYCLES=2 instance under directed and random
// traffic, plus a WAIT_CYCLES=0 instance for the back-to-back ack cadence.
module tb_data_ram_resp;
    localparam int AW   = 10;
    localparam int WC_A = 2;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        ce_a, we_a, ack_a, busy_a;
    logic [31:0] addr_a, wd_a, rd_a;
    logic [3:0]  sel_a;
    logic        ce_b, we_b, ack_b, busy_b;
    logic [31:0] addr_b, wd_b, rd_b;
    logic [3:0]  sel_b;

    data_ram_resp #(.ADDR_W(AW), .WAIT_CYCLES(WC_A)) dut_a (
        .clk(clk), .rst(rst), .mem_ce(ce_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_sel(sel_a), .mem_wdata(wd_a), .mem_rdata(rd_a), .mem_ack(ack_a), .busy(busy_a));

    data_ram_resp #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .mem_ce(ce_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_sel(sel_b), .mem_wdata(wd_b), .mem_rdata(rd_b), .mem_ack(ack_b), .busy(busy_b));

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_a [int];
    logic [31:0] model_b [int];
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    logic        prev_ack_a = 1'b0;
    logic        prev_ack_b = 1'b0;
    bit          open_a = 1'b0;

    function automatic logic [31:0] lmask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop an expectation on every ack; rdata must be 0 whenever ack is low.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (ack_a) begin
                if (exp_a.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL a_unexpected_ack: got ack with empty scoreboard at %0t", $time);
                end else check("a_rdata", rd_a, exp_a.pop_front());
            end else check("a_rdata_idle", rd_a, 32'h0);
            check("a_ack_double", {31'b0, ack_a & prev_ack_a}, 32'h0);
            if (ack_b) begin
                if (exp_b.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b_unexpected_ack: got ack with empty scoreboard at %0t", $time);
                end else check("b_rdata", rd_b, exp_b.pop_front());
            end else check("b_rdata_idle", rd_b, 32'h0);
        end
        prev_ack_a = ack_a;
        prev_ack_b = ack_b;
    end

    // Presents a request on instance A at a negedge and waits for its ack.
    task automatic req_a(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wd, input bit b2b, input bit drop);
        int          idx = int'(addr[AW+1:2]);
        logic [31:0] m   = lmask(sel);
        int          lat = 0;
        bit          got = 1'b0;
        ce_a = 1'b1; we_a = we; addr_a = addr; sel_a = sel; wd_a = wd;
        if (we) begin
            model_a[idx] = (model_a[idx] & ~m) | (wd & m);
            exp_a.push_back(32'h0);
        end else exp_a.push_back(model_a[idx] & m);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c > int'(b2b)) check("a_busy", {31'b0, busy_a}, 32'h1);
            if (drop && c == 1) ce_a = 1'b0;
            if (ack_a) begin lat = c; got = 1'b1; break; end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL a_ack_timeout: got no ack within 20 cycles, addr %h", addr);
            void'(exp_a.pop_back());
        end else check("a_latency", lat, WC_A + 1 + int'(b2b));
        open_a = 1'b1;
    endtask

    task automatic idle_a();
        ce_a = 1'b0;
        @(negedge clk);
        check("a_busy_after", {31'b0, busy_a}, 32'h0);
        check("a_ack_after", {31'b0, ack_a}, 32'h0);
        open_a = 1'b0;
    endtask

    task automatic step_b(input bit we, input int idx, input logic [3:0] sel, input logic [31:0] wd);
        logic [31:0] m = lmask(sel);
        ce_b = 1'b1; we_b = we; addr_b = idx << 2; sel_b = sel; wd_b = wd;
        if (we) begin
            model_b[idx] = (model_b[idx] & ~m) | (wd & m);
            exp_b.push_back(32'h0);
        end else exp_b.push_back(model_b[idx] & m);
        @(negedge clk);
        check("b_ack_hi", {31'b0, ack_b}, 32'h1);
        check("b_busy_hi", {31'b0, busy_b}, 32'h1);
    endtask

    int pool [8] = '{0, 4, 8, 16, 5, 6, 7, 9};

    initial begin
        rst = 1'b1;
        ce_a = 1'b1; we_a = 1'b1; addr_a = 32'h40; sel_a = 4'hF; wd_a = 32'h0;
        ce_b = 1'b0; we_b = 1'b0; addr_b = 32'h0; sel_b = 4'h0; wd_b = 32'h0;
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_ack", {31'b0, ack_a}, 32'h0);
            check("rst_busy", {31'b0, busy_a}, 32'h0);
            check("rst_rdata", rd_a, 32'h0);
        end
        rst = 1'b1;
        // capture on the first edge after release: latency check in req_a covers it
        for (int k = 0; k < 8; k++) begin
            logic [31:0] init_v;
            init_v = (pool[k] == 16) ? 32'h0 : (pool[k] == 8) ? 32'h11223344 : $urandom;
            req_a(1'b1, pool[k] << 2, 4'hF, init_v, open_a, 1'b0);
        end
        idle_a();

        // store then back-to-back load of the same word
        req_a(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
        req_a(1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 1'b0);
        idle_a();

        // byte lanes
        req_a(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0, 1'b0);
        req_a(1'b0, 32'h20, 4'hF, 32'h0, 1'b1, 1'b0);
        req_a(1'b0, 32'h20, 4'b0011, 32'h0, 1'b1, 1'b0);
        req_a(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 1'b1, 1'b0);
        req_a(1'b0, 32'h20, 4'b0000, 32'h0, 1'b1, 1'b0);
        req_a(1'b0, 32'h20, 4'hF, 32'h0, 1'b1, 1'b0);
        idle_a();

        // reset in the middle of a store: never committed, never acked
        ce_a = 1'b1; we_a = 1'b1; addr_a = 32'h40; sel_a = 4'hF; wd_a = 32'hFFFFFFFF;
        @(negedge clk);
        check("abort_busy", {31'b0, busy_a}, 32'h1);
        rst = 1'b0; ce_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_ack", {31'b0, ack_a}, 32'h0);
            check("abort_busy_rst", {31'b0, busy_a}, 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        req_a(1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 1'b0);
        idle_a();

        // address wrap with ce dropped during WAIT, then aliased loads
        req_a(1'b1, 32'h1000, 4'hF, 32'h5A5A5A5A, 1'b0, 1'b1);
        idle_a();
        req_a(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
        req_a(1'b0, 32'hFFFFF003, 4'hF, 32'h0, 1'b1, 1'b0);
        idle_a();

        // random traffic over the initialised pool
        for (int i = 0; i < 40; i++) begin
            bit          b2b, drop;
            logic [31:0] addr;
            b2b  = open_a && ($urandom_range(0, 1) == 1);
            if (open_a && !b2b) idle_a();
            drop = !b2b && ($urandom_range(0, 3) == 0);
            addr = ($urandom & 32'hFFFFF003) | (pool[$urandom_range(0, 7)] << 2);
            req_a($urandom_range(0, 1) == 1, addr, 4'($urandom), $urandom, b2b, drop);
        end
        if (open_a) idle_a();

        // zero wait states with ce held high across four requests
        step_b(1'b1, 3, 4'hF, 32'hCAFEF00D);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("b_ack_lo", {31'b0, ack_b}, 32'h0);
            check("b_busy_lo", {31'b0, busy_b}, 32'h0);
            case (k)
                1: step_b(1'b0, 3, 4'hF, 32'h0);
                2: step_b(1'b1, 3, 4'b0010, 32'h0000AB00);
                default: step_b(1'b0, 3, 4'hF, 32'h0);
            endcase
        end
        ce_b = 1'b0;
        repeat (2) @(negedge clk);
        check("b_ack_end", {31'b0, ack_b}, 32'h0);
        check("a_queue_empty", exp_a.size(), 32'h0);
        check("b_queue_empty", exp_b.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got no completion by %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
